// File: rtl/queue2_serializer.sv
// Read-side engine for the 2-entry lookahead queue: pops the head word and
// shifts it out MSB-first on o_sdo, one bit per i_tick, back-to-back when possible.
module queue2_serializer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_tick,
    input  logic [1:0]       i_vld,
    input  logic [WIDTH-1:0] i_data0,
    output logic             o_rd,
    output logic             o_sdo,
    output logic             o_active,
    output logic             o_more,
    output logic             o_word_done,
    output logic [CNT_W-1:0] o_words
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             done_q, done_d;
    logic             eow;
    logic             load;

    // Only the head-valid flag steers the engine; the second occupancy bit is informational.
    logic unused_vld1;
    assign unused_vld1 = i_vld[1];

    assign eow  = (state_q == SHIFT) && i_tick && (bitcnt_q == LAST_BIT);
    assign load = i_en && i_vld[0] && ((state_q == IDLE) || eow);

    // NOTE: every flop below uses non-blocking assignment so all registers
    // update together from the same pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SHIFT;
        end else if (eow) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg_q  <= '1;
            bitcnt_q <= '0;
            words_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            words_q  <= words_d;
            done_q   <= done_d;
        end
    end

    // NOTE: each comb output starts from a default so no path leaves it unassigned (no latches).
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        words_d  = words_q;
        done_d   = eow;
        if (eow) begin
            words_d = words_q + 1'b1;
        end
        if (load) begin
            shreg_d  = i_data0;
            bitcnt_d = '0;
        end else if (eow) begin
            shreg_d = '1;
        end else if ((state_q == SHIFT) && i_tick) begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b1};
            bitcnt_d = bitcnt_q + 1'b1;
        end
    end

    always_comb begin
        o_rd        = load;
        o_active    = (state_q == SHIFT);
        o_sdo       = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b1;
        o_more      = (state_q == SHIFT) && i_vld[0];
        o_word_done = done_q;
        o_words     = words_q;
    end

endmodule

// File: tb/tb_queue2_serializer.sv
// Scoreboard bench for queue2_serializer: a queue model feeds words, a monitor
// reassembles the serial stream and compares against expected words.
module tb_queue2_serializer;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_en = 1'b0;
    logic             i_tick = 1'b0;
    logic [1:0]       i_vld = 2'b00;
    logic [WIDTH-1:0] i_data0 = '0;
    logic             o_rd;
    logic             o_sdo;
    logic             o_active;
    logic             o_more;
    logic             o_word_done;
    logic [CNT_W-1:0] o_words;

    queue2_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_tick      (i_tick),
        .i_vld       (i_vld),
        .i_data0     (i_data0),
        .o_rd        (o_rd),
        .o_sdo       (o_sdo),
        .o_active    (o_active),
        .o_more      (o_more),
        .o_word_done (o_word_done),
        .o_words     (o_words)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int pushes = 0;
    logic [WIDTH-1:0] tbq[$];
    logic [WIDTH-1:0] expq[$];
    bit rand_tick = 1'b0;
    int tick_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        i_vld   = {tbq.size() > 1, tbq.size() > 0};
        i_data0 = (tbq.size() > 0) ? tbq[0] : '0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w, input bit expect_out);
        tbq.push_back(w);
        if (expect_out) expq.push_back(w);
        pushes++;
        refresh();
    endtask

    // Queue model: pop on the edge where o_rd is high, update flags just after the edge.
    logic rd_s;
    logic v_s;
    always @(posedge i_clk) begin
        rd_s = o_rd;
        v_s  = i_vld[0];
        if (rd_s) check("rd_only_when_valid", 32'(v_s), 32'd1);
        #1;
        if (rd_s && tbq.size() > 0) begin
            void'(tbq.pop_front());
            pops++;
        end
        refresh();
    end

    always @(posedge i_clk) begin
        #1;
        if (rand_tick) begin
            i_tick = ($urandom_range(0, 1) == 1);
        end else begin
            tick_cnt = (tick_cnt + 1) % 4;
            i_tick   = (tick_cnt == 0);
        end
    end

    // Monitor: the bit on o_sdo at a tick is the bit whose period ends on that tick.
    logic [WIDTH-1:0] acc = '0;
    logic [WIDTH-1:0] exp_w;
    int nbits = 0;
    int mon_cnt = 0;
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (!o_active) check("idle_sdo_high", 32'(o_sdo), 32'd1);
            if (o_word_done) begin
                check("word_bit_count", 32'(nbits), 32'(WIDTH));
                if (expq.size() > 0) begin
                    exp_w = expq.pop_front();
                    check("word_data", 32'(acc), 32'(exp_w));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL word_data: got %0h expected no word at %0t", acc, $time);
                end
                mon_cnt = (mon_cnt + 1) % (1 << CNT_W);
                check("o_words_count", 32'(o_words), 32'(mon_cnt));
                nbits = 0;
                acc   = '0;
            end
            if (i_tick && o_active) begin
                acc = {acc[WIDTH-2:0], o_sdo};
                nbits++;
            end
        end
    end

    always @(negedge i_rst_n) begin
        nbits   = 0;
        acc     = '0;
        mon_cnt = 0;
    end

    task automatic wait_done(input string name);
        int n = 0;
        while (n < 400) begin
            @(negedge i_clk);
            if (o_word_done) break;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout expected o_word_done", name);
        end
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 1000) begin
            @(negedge i_clk);
            if (i_tick && o_active) seen++;
            cyc++;
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL wait_ticks: got %0d ticks expected %0d", seen, n);
        end
    endtask

    task automatic wait_active();
        int cyc = 0;
        while (!o_active && cyc < 100) begin
            @(negedge i_clk);
            cyc++;
        end
        if (!o_active) begin
            checks++;
            errors++;
            $display("FAIL wait_active: got inactive expected active");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int nb;
        bit started;
        bit gap;
        bit more1;
        bit more2;
        logic [15:0] stream;

        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_sdo", 32'(o_sdo), 32'd1);
        check("rst_active", 32'(o_active), 32'd0);
        check("rst_done", 32'(o_word_done), 32'd0);
        check("rst_words", 32'(o_words), 32'd0);
        check("rst_rd", 32'(o_rd), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        // Single word 0xA5
        push_word(8'hA5, 1'b1);
        p0 = pops;
        i_en = 1'b1;
        @(negedge i_clk);
        check("t1_active_after_load", 32'(o_active), 32'd1);
        check("t1_msb_first", 32'(o_sdo), 32'd1);
        check("t1_more_low", 32'(o_more), 32'd0);
        wait_done("t1_done");
        check("t1_words", 32'(o_words), 32'd1);
        check("t1_idle", 32'(o_active), 32'd0);
        check("t1_sdo_idle", 32'(o_sdo), 32'd1);
        check("t1_pops", 32'(pops - p0), 32'd1);

        // Back-to-back 0x81, 0x7E
        i_en = 1'b0;
        @(negedge i_clk);
        push_word(8'h81, 1'b1);
        push_word(8'h7E, 1'b1);
        p0 = pops;
        i_en = 1'b1;
        nb = 0; started = 0; gap = 0; more1 = 1; more2 = 0; stream = '0;
        for (int c = 0; c < 300 && nb < 16; c++) begin
            @(negedge i_clk);
            if (o_active) started = 1;
            if (started && !o_active) gap = 1;
            if (i_tick && o_active) begin
                stream = {stream[14:0], o_sdo};
                if (nb < 8) more1 = more1 & o_more;
                else more2 = more2 | o_more;
                nb++;
            end
        end
        check("t2_stream", 32'(stream), 32'h817E);
        check("t2_no_gap", 32'(gap), 32'd0);
        check("t2_more_first", 32'(more1), 32'd1);
        check("t2_more_second", 32'(more2), 32'd0);
        wait_done("t2_done");
        check("t2_pops", 32'(pops - p0), 32'd2);
        check("t2_words", 32'(o_words), 32'd3);
        check("t2_idle", 32'(o_active), 32'd0);

        // 0x0F with 0x3C arriving mid-word: back-to-back
        push_word(8'h0F, 1'b1);
        wait_active();
        wait_ticks(4);
        push_word(8'h3C, 1'b1);
        wait_done("t3a_done");
        check("t3_back_to_back", 32'(o_active), 32'd1);
        // 0x3C drains with an empty queue; 0xC3 arrives late, after an idle gap
        wait_done("t3b_done");
        check("t3_idle_gap", 32'(o_active), 32'd0);
        check("t3_idle_sdo", 32'(o_sdo), 32'd1);
        @(negedge i_clk);
        push_word(8'hC3, 1'b1);
        wait_done("t3c_done");

        // Enable dropped mid-word with 0x55 queued
        push_word(8'hF0, 1'b1);
        wait_active();
        push_word(8'h55, 1'b1);
        wait_ticks(3);
        i_en = 1'b0;
        p0 = pops;
        wait_done("t4_done");
        check("t4_idle", 32'(o_active), 32'd0);
        check("t4_queue_kept", 32'(tbq.size()), 32'd1);
        repeat (6) @(negedge i_clk);
        check("t4_no_pop", 32'(pops - p0), 32'd0);
        check("t4_still_idle", 32'(o_active), 32'd0);
        i_en = 1'b1;
        wait_done("t4_resume");
        check("t4_resume_pop", 32'(pops - p0), 32'd1);

        // Asynchronous reset at bit 5; 0x96 is aborted, queued 0x3A goes next
        push_word(8'h96, 1'b0);
        wait_active();
        push_word(8'h3A, 1'b1);
        wait_ticks(5);
        @(posedge i_clk);
        #2;
        p0 = pops;
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_sdo", 32'(o_sdo), 32'd1);
        check("t5_rst_active", 32'(o_active), 32'd0);
        check("t5_rst_words", 32'(o_words), 32'd0);
        check("t5_rst_rd_pop", 32'(pops - p0), 32'd0);
        #1;
        i_rst_n = 1'b1;
        check("t5_queue_kept", 32'(tbq.size()), 32'd1);
        wait_done("t5_done");
        check("t5_words", 32'(o_words), 32'd1);

        // Random ticks and queue timing; 16 more words wraps the 4-bit count to 1
        rand_tick = 1'b1;
        for (int w = 0; w < 16; w++) begin
            repeat ($urandom_range(0, 20)) @(negedge i_clk);
            for (int c = 0; c < 500 && tbq.size() >= 2; c++) @(negedge i_clk);
            push_word(8'($urandom_range(0, 255)), 1'b1);
        end
        for (int c = 0; c < 3000 && (expq.size() > 0 || o_active); c++) @(negedge i_clk);
        repeat (2) @(negedge i_clk);
        check("t6_drained", 32'(expq.size()), 32'd0);
        check("t6_queue_empty", 32'(tbq.size()), 32'd0);
        check("t6_wrap", 32'(o_words), 32'd1);
        check("t6_pops_match", 32'(pops), 32'(pushes));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
